// File: rtl/scr1_imem_arb.sv
`timescale 1ns/1ps
// scr1_imem_arb: shares the SCR1 IMEM read port between the fetch unit (M0)
// and a secondary instruction reader (M1). Round-robin grant with a lock that
// holds the owner while the bridge stalls, and an in-order ID FIFO that steers
// each bridge response back to the requester that issued it.
module scr1_imem_arb #(
    parameter int OUTSTD_MAX = 2,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          m0_req,
    output logic          m0_req_ack,
    input  logic [AW-1:0] m0_addr,
    output logic [DW-1:0] m0_rdata,
    output logic [1:0]    m0_resp,

    input  logic          m1_req,
    output logic          m1_req_ack,
    input  logic [AW-1:0] m1_addr,
    output logic [DW-1:0] m1_rdata,
    output logic [1:0]    m1_resp,

    output logic          s_req,
    input  logic          s_req_ack,
    output logic [AW-1:0] s_addr,
    input  logic [DW-1:0] s_rdata,
    input  logic [1:0]    s_resp,

    output logic          err_unexp_resp
);

    typedef enum logic {
        REQ_M0 = 1'b0,
        REQ_M1 = 1'b1
    } req_id_e;

    // The ID storage is always four deep so the 2-bit pointers index it
    // exactly; only the first OUTSTD_MAX entries are ever used.
    localparam int FIFO_SLOTS = 4;

    req_id_e    owner;
    logic       owner_req;
    logic       full;
    logic       accept;
    logic       resp_valid;
    logic       pop;
    req_id_e    head_id;

    logic [2:0] count_q,      count_d;
    logic [1:0] wr_ptr_q,     wr_ptr_d;
    logic [1:0] rd_ptr_q,     rd_ptr_d;
    req_id_e    ids_q [FIFO_SLOTS];
    req_id_e    ids_d [FIFO_SLOTS];
    req_id_e    rr_last_q,    rr_last_d;
    logic       lock_q,       lock_d;
    req_id_e    lock_owner_q, lock_owner_d;
    logic       err_q,        err_d;

    // Pointer advance that wraps at OUTSTD_MAX, which need not be a power of two.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(OUTSTD_MAX - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // Pick the owner (locked owner first, then round-robin on a tie) and drive the bridge request.
    always_comb begin
        if (lock_q) begin
            owner = lock_owner_q;
        end else if (m0_req && m1_req) begin
            owner = (rr_last_q == REQ_M1) ? REQ_M0 : REQ_M1;
        end else if (m1_req) begin
            owner = REQ_M1;
        end else begin
            owner = REQ_M0;
        end
        owner_req  = (owner == REQ_M1) ? m1_req : m0_req;
        full       = (count_q == 3'(OUTSTD_MAX));
        s_req      = owner_req && !full;
        s_addr     = (owner == REQ_M1) ? m1_addr : m0_addr;
        accept     = s_req && s_req_ack;
        m0_req_ack = accept && (owner == REQ_M0);
        m1_req_ack = accept && (owner == REQ_M1);
    end

    // Steer a bridge response to the requester at the head of the ID FIFO in the same cycle.
    always_comb begin
        resp_valid = (s_resp != 2'b00);
        pop        = resp_valid && (count_q != 3'd0);
        head_id    = ids_q[rd_ptr_q];
        m0_resp    = 2'b00;
        m0_rdata   = '0;
        m1_resp    = 2'b00;
        m1_rdata   = '0;
        if (pop) begin
            if (head_id == REQ_M0) begin
                m0_resp  = s_resp;
                m0_rdata = s_rdata;
            end else begin
                m1_resp  = s_resp;
                m1_rdata = s_rdata;
            end
        end
    end

    // Next-state for the ID FIFO, occupancy, round-robin history, lock and sticky error.
    always_comb begin
        ids_d        = ids_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        rr_last_d    = rr_last_q;
        lock_d       = lock_q;
        lock_owner_d = lock_owner_q;
        err_d        = err_q || (resp_valid && (count_q == 3'd0));

        if (accept) begin
            ids_d[wr_ptr_q] = owner;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
            rr_last_d       = owner;
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase

        // A stalled request keeps its owner until accepted; a full FIFO
        // leaves the lock as it is, and a withdrawn request releases it.
        if (accept) begin
            lock_d = 1'b0;
        end else if (s_req) begin
            lock_d       = 1'b1;
            lock_owner_d = owner;
        end else if (!owner_req) begin
            lock_d = 1'b0;
        end
    end

    // State registers; reset drops any in-flight IDs and favours M0 on the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= 3'd0;
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            for (int i = 0; i < FIFO_SLOTS; i++) begin
                ids_q[i] <= REQ_M0;
            end
            rr_last_q    <= REQ_M1;
            lock_q       <= 1'b0;
            lock_owner_q <= REQ_M0;
            err_q        <= 1'b0;
        end else begin
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            ids_q        <= ids_d;
            rr_last_q    <= rr_last_d;
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            err_q        <= err_d;
        end
    end

    assign err_unexp_resp = err_q;

endmodule

// File: tb/tb_scr1_imem_arb.sv
`timescale 1ns/1ps
// tb_scr1_imem_arb: directed, table-driven bench for the two-requester IMEM arbiter.
// Each record is one clock cycle: inputs are driven just after the rising
// edge and outputs are compared on the falling edge.
module tb_scr1_imem_arb;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m1_req;
    logic        m0_req_ack, m1_req_ack;
    logic [31:0] m0_addr, m1_addr;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_resp, m1_resp;
    logic        s_req, s_req_ack;
    logic [31:0] s_addr, s_rdata;
    logic [1:0]  s_resp;
    logic        err_unexp_resp;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          rst;
        logic        m0_req;
        logic [31:0] m0_addr;
        logic        m1_req;
        logic [31:0] m1_addr;
        logic        ack;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic        e_m0_ack;
        logic        e_m1_ack;
        logic        e_sreq;
        logic [31:0] e_saddr;
        logic [1:0]  e_m0_resp;
        logic [31:0] e_m0_rdata;
        logic [1:0]  e_m1_resp;
        logic [31:0] e_m1_rdata;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    scr1_imem_arb #(.OUTSTD_MAX(2), .AW(32), .DW(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .m0_req         (m0_req),
        .m0_req_ack     (m0_req_ack),
        .m0_addr        (m0_addr),
        .m0_rdata       (m0_rdata),
        .m0_resp        (m0_resp),
        .m1_req         (m1_req),
        .m1_req_ack     (m1_req_ack),
        .m1_addr        (m1_addr),
        .m1_rdata       (m1_rdata),
        .m1_resp        (m1_resp),
        .s_req          (s_req),
        .s_req_ack      (s_req_ack),
        .s_addr         (s_addr),
        .s_rdata        (s_rdata),
        .s_resp         (s_resp),
        .err_unexp_resp (err_unexp_resp)
    );

    // 100 MHz free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(
        input bit rst,
        input logic m0r, input logic [31:0] m0a,
        input logic m1r, input logic [31:0] m1a,
        input logic ack, input logic [31:0] rdata, input logic [1:0] resp,
        input logic e_m0_ack, input logic e_m1_ack, input logic e_sreq, input logic [31:0] e_saddr,
        input logic [1:0] e_m0_resp, input logic [31:0] e_m0_rdata,
        input logic [1:0] e_m1_resp, input logic [31:0] e_m1_rdata,
        input logic e_err);
        vec_t v;
        v.rst = rst; v.m0_req = m0r; v.m0_addr = m0a; v.m1_req = m1r; v.m1_addr = m1a;
        v.ack = ack; v.rdata = rdata; v.resp = resp;
        v.e_m0_ack = e_m0_ack; v.e_m1_ack = e_m1_ack; v.e_sreq = e_sreq; v.e_saddr = e_saddr;
        v.e_m0_resp = e_m0_resp; v.e_m0_rdata = e_m0_rdata;
        v.e_m1_resp = e_m1_resp; v.e_m1_rdata = e_m1_rdata;
        v.e_err = e_err;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        rst_n     = !v.rst;
        m0_req    = v.m0_req;
        m0_addr   = v.m0_addr;
        m1_req    = v.m1_req;
        m1_addr   = v.m1_addr;
        s_req_ack = v.ack;
        s_rdata   = v.rdata;
        s_resp    = v.resp;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle: drive after the rising edge, compare on the falling edge.
    task automatic runVec(input string tag, input vec_t v);
        @(posedge clk);
        #1;
        applyStimulus(v);
        @(negedge clk);
        checkOutput({tag, " m0_req_ack"}, {31'd0, m0_req_ack}, {31'd0, v.e_m0_ack});
        checkOutput({tag, " m1_req_ack"}, {31'd0, m1_req_ack}, {31'd0, v.e_m1_ack});
        checkOutput({tag, " s_req"},      {31'd0, s_req},      {31'd0, v.e_sreq});
        if (v.e_sreq) begin
            checkOutput({tag, " s_addr"}, s_addr, v.e_saddr);
        end
        checkOutput({tag, " m0_resp"},    {30'd0, m0_resp},    {30'd0, v.e_m0_resp});
        checkOutput({tag, " m0_rdata"},   m0_rdata,            v.e_m0_rdata);
        checkOutput({tag, " m1_resp"},    {30'd0, m1_resp},    {30'd0, v.e_m1_resp});
        checkOutput({tag, " m1_rdata"},   m1_rdata,            v.e_m1_rdata);
        checkOutput({tag, " err"},        {31'd0, err_unexp_resp}, {31'd0, v.e_err});
    endtask

    initial begin
        rst_n = 1'b0; m0_req = 1'b0; m1_req = 1'b0; m0_addr = '0; m1_addr = '0;
        s_req_ack = 1'b0; s_rdata = '0; s_resp = 2'b00;

        //           rst m0r m0a     m1r m1a     ack rdata         resp  em0a em1a esrq esaddr   em0rsp em0rd         em1rsp em1rd         eerr
        // reset, then M0 alone: ack at once, data next cycle
        vecs.push_back(mk(1, 0, 0,       0, 0,       0, 0,            0,   0, 0, 0, 0,       0, 0,            0, 0,            0));
        vecs.push_back(mk(0, 1, 'h200,   0, 0,       1, 0,            0,   1, 0, 1, 'h200,   0, 0,            0, 0,            0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 'h33,         1,   0, 0, 0, 0,       1, 'h33,         0, 0,            0));
        // both request from reset: M0 first, then M1; responses in order
        vecs.push_back(mk(1, 0, 0,       0, 0,       0, 0,            0,   0, 0, 0, 0,       0, 0,            0, 0,            0));
        vecs.push_back(mk(0, 1, 'h100,   1, 'h300,   1, 0,            0,   1, 0, 1, 'h100,   0, 0,            0, 0,            0));
        vecs.push_back(mk(0, 0, 0,       1, 'h300,   1, 'hAAAA0001,   1,   0, 1, 1, 'h300,   1, 'hAAAA0001,   0, 0,            0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 'hBBBB0002,   1,   0, 0, 0, 0,       0, 0,            1, 'hBBBB0002,   0));
        // back-to-back ties alternate M0 then M1; error response routed to M1
        vecs.push_back(mk(0, 1, 'h110,   1, 'h310,   1, 0,            0,   1, 0, 1, 'h110,   0, 0,            0, 0,            0));
        vecs.push_back(mk(0, 1, 'h110,   1, 'h310,   1, 'h11,         1,   0, 1, 1, 'h310,   1, 'h11,         0, 0,            0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0,            2,   0, 0, 0, 0,       0, 0,            2, 0,            0));
        // M1 stalled three cycles, M0 joins: lock holds M1
        vecs.push_back(mk(0, 0, 0,       1, 'h400,   0, 0,            0,   0, 0, 1, 'h400,   0, 0,            0, 0,            0));
        vecs.push_back(mk(0, 1, 'h500,   1, 'h400,   0, 0,            0,   0, 0, 1, 'h400,   0, 0,            0, 0,            0));
        vecs.push_back(mk(0, 1, 'h500,   1, 'h400,   0, 0,            0,   0, 0, 1, 'h400,   0, 0,            0, 0,            0));
        vecs.push_back(mk(0, 1, 'h500,   1, 'h400,   1, 0,            0,   0, 1, 1, 'h400,   0, 0,            0, 0,            0));
        vecs.push_back(mk(0, 1, 'h500,   0, 0,       1, 0,            0,   1, 0, 1, 'h500,   0, 0,            0, 0,            0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 'h44,         1,   0, 0, 0, 0,       0, 0,            1, 'h44,         0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 'h55,         1,   0, 0, 0, 0,       1, 'h55,         0, 0,            0));
        // fill to OUTSTD_MAX, pop while full does not unblock until next cycle
        vecs.push_back(mk(0, 1, 'h600,   0, 0,       1, 0,            0,   1, 0, 1, 'h600,   0, 0,            0, 0,            0));
        vecs.push_back(mk(0, 1, 'h604,   0, 0,       1, 0,            0,   1, 0, 1, 'h604,   0, 0,            0, 0,            0));
        vecs.push_back(mk(0, 1, 'h608,   0, 0,       1, 0,            0,   0, 0, 0, 0,       0, 0,            0, 0,            0));
        vecs.push_back(mk(0, 1, 'h608,   0, 0,       1, 'h66,         1,   0, 0, 0, 0,       1, 'h66,         0, 0,            0));
        vecs.push_back(mk(0, 1, 'h608,   0, 0,       1, 0,            0,   1, 0, 1, 'h608,   0, 0,            0, 0,            0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 'h77,         1,   0, 0, 0, 0,       1, 'h77,         0, 0,            0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 'h88,         1,   0, 0, 0, 0,       1, 'h88,         0, 0,            0));
        // same-cycle accept (M1) and error response for M0; count stays at 1
        vecs.push_back(mk(0, 1, 'h700,   0, 0,       1, 0,            0,   1, 0, 1, 'h700,   0, 0,            0, 0,            0));
        vecs.push_back(mk(0, 0, 0,       1, 'h800,   1, 0,            2,   0, 1, 1, 'h800,   2, 0,            0, 0,            0));
        vecs.push_back(mk(0, 1, 'h900,   0, 0,       1, 'h99,         1,   1, 0, 1, 'h900,   0, 0,            1, 'h99,         0));
        vecs.push_back(mk(0, 1, 'h904,   0, 0,       1, 0,            0,   1, 0, 1, 'h904,   0, 0,            0, 0,            0));
        vecs.push_back(mk(0, 1, 'h908,   0, 0,       1, 0,            0,   0, 0, 0, 0,       0, 0,            0, 0,            0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 'hA1,         1,   0, 0, 0, 0,       1, 'hA1,         0, 0,            0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 'hA2,         1,   0, 0, 0, 0,       1, 'hA2,         0, 0,            0));
        // unexpected response with empty FIFO: dropped, error sticky until reset
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 'hDEAD,       1,   0, 0, 0, 0,       0, 0,            0, 0,            0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0,            0,   0, 0, 0, 0,       0, 0,            0, 0,            1));
        vecs.push_back(mk(0, 1, 'hA00,   0, 0,       1, 0,            0,   1, 0, 1, 'hA00,   0, 0,            0, 0,            1));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 'h12,         1,   0, 0, 0, 0,       1, 'h12,         0, 0,            1));
        vecs.push_back(mk(1, 0, 0,       0, 0,       0, 0,            0,   0, 0, 0, 0,       0, 0,            0, 0,            0));
        vecs.push_back(mk(0, 0, 0,       0, 0,       0, 0,            0,   0, 0, 0, 0,       0, 0,            0, 0,            0));

        for (int i = 0; i < vecs.size(); i++) begin
            runVec($sformatf("vec%0d", i), vecs[i]);
        end

        // Hand-written: M1 locked through a variable stall while M0 waits with tie priority.
        runVec("lock start", mk(0, 0, 0, 1, 'hB00, 0, 0, 0, 0, 0, 1, 'hB00, 0, 0, 0, 0, 0));
        for (int w = 0; w < 3; w++) begin
            runVec($sformatf("lock stall%0d", w),
                   mk(0, 1, 'hC00, 1, 'hB00, 0, 0, 0, 0, 0, 1, 'hB00, 0, 0, 0, 0, 0));
        end
        runVec("lock accept", mk(0, 1, 'hC00, 1, 'hB00, 1, 0, 0, 0, 1, 1, 'hB00, 0, 0, 0, 0, 0));
        runVec("lock next",   mk(0, 1, 'hC00, 0, 0,     1, 0, 0, 1, 0, 1, 'hC00, 0, 0, 0, 0, 0));
        runVec("lock resp1",  mk(0, 0, 0, 0, 0, 0, 'hB0, 1, 0, 0, 0, 0, 0, 0,    1, 'hB0, 0));
        runVec("lock resp2",  mk(0, 0, 0, 0, 0, 0, 'hC0, 1, 0, 0, 0, 0, 1, 'hC0, 0, 0,    0));

        // Hand-written: sticky error persists over idle cycles and clears on reset.
        runVec("sticky set", mk(0, 0, 0, 0, 0, 0, 'hEE, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++) begin
            runVec($sformatf("sticky hold%0d", k), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        end
        runVec("sticky reset", mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        runVec("sticky after", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
